// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Write-side initiator for the register file. Merges the single-cycle ALU
//   writeback stream and the variable-latency load-return stream onto the
//   single write port (RegWrite/WriteRegister/WriteData). Loads that lose
//   arbitration wait in a small in-order FIFO. A newer ALU write squashes
//   queued loads to the same register so architectural order holds.
//
//   Optional feature macro: WB_FWD_EN (enables the forwarding lookup).
//
// Ports:
//   clk, reset_n                       clock (rising edge), async active-low reset
//   alu_valid, alu_rd, alu_data        ALU writeback, always accepted
//   ld_valid, ld_ready, ld_rd, ld_data load-return handshake
//   RegWrite, WriteRegister, WriteData registered register-file write port
//   busy                               load FIFO non-empty
//   fwd_rd, fwd_hit, fwd_data          forwarding lookup (zero when WB_FWD_EN undefined)
module regfile_write_arbiter #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 4,
  parameter int ZERO_REG = 31
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_rd,
  input  logic [DATA_W-1:0] ld_data,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] WriteRegister,
  output logic [DATA_W-1:0] WriteData,
  output logic              busy,
  input  logic [ADDR_W-1:0] fwd_rd,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] ZERO_IDX  = ADDR_W'(ZERO_REG);
  localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(DEPTH);

  // FIFO storage and control
  logic [ADDR_W-1:0] fifo_rd_q   [DEPTH];
  logic [DATA_W-1:0] fifo_data_q [DEPTH];
  logic [DEPTH-1:0]  fifo_vld_q, fifo_vld_d;
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;

  // Registered write port
  logic              regwrite_q;
  logic [ADDR_W-1:0] wreg_q;
  logic [DATA_W-1:0] wdata_q;

  // Arbitration signals
  logic              alu_take_s, ld_acc_s, fifo_ne_s, pop_s, push_s;
  logic              sel_we_s;
  logic [ADDR_W-1:0] sel_rd_s;
  logic [DATA_W-1:0] sel_data_s;

  // Readiness comes only from registered count so a same-cycle pop never frees a slot early.
  assign ld_ready   = (count_q < DEPTH_CNT);
  assign ld_acc_s   = ld_valid && ld_ready;
  assign alu_take_s = alu_valid && (alu_rd != ZERO_IDX);
  assign fifo_ne_s  = (count_q != {CNT_W{1'b0}});
  // A non-zero load goes to the FIFO whenever it cannot be written straight through.
  assign push_s     = ld_acc_s && (ld_rd != ZERO_IDX) && (alu_take_s || fifo_ne_s);
  assign busy       = fifo_ne_s;

  assign RegWrite      = regwrite_q;
  assign WriteRegister = wreg_q;
  assign WriteData     = wdata_q;

  // Priority selection of the write for next cycle: ALU, then FIFO head, then bypass load.
  always_comb begin
    pop_s      = 1'b0;
    sel_we_s   = 1'b0;
    sel_rd_s   = wreg_q;
    sel_data_s = wdata_q;
    if (alu_take_s) begin
      sel_we_s   = 1'b1;
      sel_rd_s   = alu_rd;
      sel_data_s = alu_data;
    end else if (fifo_ne_s) begin
      // A squashed head still consumes the slot; it is simply not written.
      pop_s = 1'b1;
      if (fifo_vld_q[head_q]) begin
        sel_we_s   = 1'b1;
        sel_rd_s   = fifo_rd_q[head_q];
        sel_data_s = fifo_data_q[head_q];
      end else begin
        sel_we_s = 1'b0;
      end
    end else if (ld_acc_s && (ld_rd != ZERO_IDX)) begin
      sel_we_s   = 1'b1;
      sel_rd_s   = ld_rd;
      sel_data_s = ld_data;
    end else begin
      sel_we_s = 1'b0;
    end
  end

  // FIFO next state: squash older entries, retire head, append the new load.
  always_comb begin
    fifo_vld_d = fifo_vld_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    if (alu_take_s) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (fifo_rd_q[i] == alu_rd) begin
          fifo_vld_d[i] = 1'b0;
        end else begin
          fifo_vld_d[i] = fifo_vld_d[i];
        end
      end
    end else begin
      fifo_vld_d = fifo_vld_q;
    end
    if (pop_s) begin
      fifo_vld_d[head_q] = 1'b0;
      head_d             = head_q + PTR_W'(1);
    end else begin
      head_d = head_q;
    end
    // Applied after the squash so a same-cycle load counts as younger.
    if (push_s) begin
      fifo_vld_d[tail_q] = 1'b1;
      tail_d             = tail_q + PTR_W'(1);
    end else begin
      tail_d = tail_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO control and storage registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fifo_vld_q <= {DEPTH{1'b0}};
      head_q     <= {PTR_W{1'b0}};
      tail_q     <= {PTR_W{1'b0}};
      count_q    <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        fifo_rd_q[i]   <= {ADDR_W{1'b0}};
        fifo_data_q[i] <= {DATA_W{1'b0}};
      end
    end else begin
      fifo_vld_q <= fifo_vld_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      if (push_s) begin
        fifo_rd_q[tail_q]   <= ld_rd;
        fifo_data_q[tail_q] <= ld_data;
      end
    end
  end

  // Registered write port; index/data hold when nothing is selected.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      regwrite_q <= 1'b0;
      wreg_q     <= {ADDR_W{1'b0}};
      wdata_q    <= {DATA_W{1'b0}};
    end else begin
      regwrite_q <= sel_we_s;
      wreg_q     <= sel_rd_s;
      wdata_q    <= sel_data_s;
    end
  end

`ifdef WB_FWD_EN
  logic [PTR_W-1:0] fwd_idx_s;

  // Forwarding search: scan oldest to youngest so the youngest match wins.
  always_comb begin
    fwd_hit   = 1'b0;
    fwd_data  = {DATA_W{1'b0}};
    fwd_idx_s = head_q;
    if (fwd_rd != ZERO_IDX) begin
      if (regwrite_q && (wreg_q == fwd_rd)) begin
        fwd_hit  = 1'b1;
        fwd_data = wdata_q;
      end else begin
        fwd_hit = 1'b0;
      end
      for (int k = 0; k < DEPTH; k++) begin
        fwd_idx_s = head_q + PTR_W'(k);
        if ((CNT_W'(k) < count_q) && fifo_vld_q[fwd_idx_s] &&
            (fifo_rd_q[fwd_idx_s] == fwd_rd)) begin
          fwd_hit  = 1'b1;
          fwd_data = fifo_data_q[fwd_idx_s];
        end else begin
          fwd_hit = fwd_hit;
        end
      end
    end else begin
      fwd_hit = 1'b0;
    end
  end
`else
  logic unused_fwd_s;
  assign unused_fwd_s = ^fwd_rd;
  assign fwd_hit      = 1'b0;
  assign fwd_data     = {DATA_W{1'b0}};
`endif

endmodule
